read_datapath: RTL and testbench
================================

# read_datapath

Drive-side read serializer for the ESDI emulator, the transmit counterpart of `write_datapath`. It takes per-sector byte frames from an AXI-stream and plays them onto the ESDI read data/clock pair while the controller holds read gate. Each frame is tagged with its sector number in `in_tid`. Sector position comes from `sector_timer` (`sector_number`, `esdi_sector`); bit-cell timing comes from an external half-cell strobe.

## Interface
- `PREAMBLE_BITS`, default 96: zero bits sent after read gate is sampled high, before the sync byte.
- `SYNC_BYTE`, default 8'hA1: sync pattern sent MSB first, immediately before data.
- `aclk`  in  1  single clock for all logic.
- `areset`  in  1  reset; asynchronous, active-high.
- `enable`  in  1  block enable; low acts as gate drop.
- `sector_number`  in  8  current sector under the head.
- `esdi_sector`  in  1  sector pulse (level); the block acts on its rising edge.
- `half_strobe`  in  1  one-cycle pulse at 2x the bit rate.
- `esdi_read_gate`  in  1  controller read gate, active-high.
- `in_tvalid` / `in_tready` / `in_tdata[7:0]` / `in_tlast` / `in_tid[7:0]`  in/out/in/in/in  sector frame stream.
- `esdi_read_data`  out  1  NRZ read data, MSB first.
- `esdi_read_clock`  out  1  read clock.
- `busy`  out  1  high in any state other than IDLE.
- `sector_done`  out  1  one-cycle pulse when the last data bit cell completes.
- `underrun`  out  1  sticky flag; cleared at the next ARMED entry.
- `tid_mismatch`  out  1  sticky flag; cleared at the next ARMED entry.

## Operation
- Every output resets to 0; state resets to IDLE.
- `esdi_sector` is registered once internally; a rising edge is detected from that registered copy.
- States:
  - IDLE: a sector rising edge with `enable`=1 goes to ARMED.
  - ARMED: a further sector edge re-arms on the new sector and stays in ARMED. When gate=1:
    - head beat valid and `in_tid==sector_number` goes to PREAMBLE;
    - head beat valid with a different tid goes to MISS and sets tid_mismatch;
    - `in_tvalid`=0 goes to MISS and sets underrun.
  - PREAMBLE: sends PREAMBLE_BITS zero bit cells, then goes to SYNC.
  - SYNC: sends 8 bits of SYNC_BYTE, then goes to DATA.
  - DATA: sends bytes from the stream.
  - POST: sends zeros until gate drops, then goes to IDLE.
  - MISS: sends zeros until gate drops, then goes to IDLE. No stream beats are consumed.
  - DRAIN: `in_tready`=1 continuously; on the `tlast` handshake, goes to IDLE.
- Bit cell = two half_strobes. A 1-bit phase register clears on ARMED exit.
  - Phase-0 strobe: present the next bit on esdi_read_data; drive esdi_read_clock low.
  - Phase-1 strobe: drive esdi_read_clock high.
  - Data is therefore stable for a full half cell before each rising edge.
- Byte fetch in DATA: `in_tready` is high for exactly the phase-0 strobe cycle of each byte's MSB cell.
  - Handshake: load `in_tdata` into the shift register; remember `in_tlast`.
  - No tvalid: load 8'h00, set underrun, and continue in DATA. This repeats per byte until gate drops.
  - After the 8th cell of the tlast byte completes, pulse sector_done and go to POST.
- Gate drop or `enable`=0 in PREAMBLE, SYNC, or DATA:
  - Goes to DRAIN if the frame has not been fully consumed, including the case where no beat is taken yet in PREAMBLE or SYNC.
  - Otherwise goes to IDLE.
  - Data and clock go to 0 immediately.
- Gate drop or `enable`=0 in ARMED, MISS, or POST: goes to IDLE.
- Outside PREAMBLE, SYNC, DATA, POST, and MISS, esdi_read_data and esdi_read_clock are 0.
- `areset` mid-frame: returns to IDLE with no drain. The upstream FIFO must be reset together with this block.

## Timing
- All outputs are registered. A strobe in cycle N changes data/clock in cycle N+1.
- Gate is sampled every cycle. Gate high in ARMED starts the first preamble cell at the next half_strobe.
- `in_tready` is combinational from state, phase and half_strobe. It never depends on `in_tvalid`.
- sector_done is high in the cycle after the last phase-1 strobe of the final byte.
- A sector edge and a gate rise in the same cycle while ARMED: the gate rise wins, using the updated sector_number.
- A sector edge in any state other than IDLE or ARMED is ignored.
- The half-cell counter has no wrap issues. The preamble counter is sized to PREAMBLE_BITS.

## Test plan
- Normal read: PREAMBLE_BITS=16, SYNC=A1, frame tid=5 of bytes 3C,81 (tlast on 81); sector 5 edge, then gate=1.
  - Required: 16 zeros, then 10100001 00111100 10000001 on esdi_read_data, sampled on each read-clock rise.
  - Then sector_done for 1 cycle, then zeros until gate=0.
- Tid mismatch: head tid=7, sector 5, gate=1.
  - Required: zeros only, tid_mismatch=1, tvalid stays pending with no tready.
  - Next sector edge to sector 7 plus gate: frame is sent correctly and tid_mismatch clears.
- Underrun: 3-byte frame with tvalid dropped before byte 2.
  - Required: byte 2 and later are sent as 00 and underrun=1.
  - Restoring tvalid before a later fetch resumes consumption; tlast then ends the frame.
- Gate abort: gate drops after 4 data bits of byte 0 of a 4-byte frame.
  - Required: data/clock=0 the next cycle.
  - Remaining 3 beats are drained with tready=1, then IDLE with busy=0.
- Async reset asserted mid-SYNC: all outputs are 0 immediately and state is IDLE.
  - After release, the block waits for a fresh sector edge.

Source files
------------

// File: rtl/read_datapath.sv
// ESDI drive-side read serializer: plays one AXI-stream sector frame onto the read data/clock pair
// as preamble zeros, a sync byte and NRZ data bytes, all paced by an external half-cell strobe.
module read_datapath #(
  parameter int unsigned PREAMBLE_BITS = 96,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA1
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       enable,
  input  logic [7:0] sector_number,
  input  logic       esdi_sector,
  input  logic       half_strobe,
  input  logic       esdi_read_gate,
  input  logic       in_tvalid,
  output logic       in_tready,
  input  logic [7:0] in_tdata,
  input  logic       in_tlast,
  input  logic [7:0] in_tid,
  output logic       esdi_read_data,
  output logic       esdi_read_clock,
  output logic       busy,
  output logic       sector_done,
  output logic       underrun,
  output logic       tid_mismatch
);

  localparam int unsigned PreW = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(PREAMBLE_BITS - 1);

  typedef enum logic [2:0] {
    StIdle, StArmed, StPreamble, StSync, StData, StPost, StMiss, StDrain
  } state_e;

  state_e          r_state, w_state_next;
  logic            r_sector;
  logic            r_phase, w_phase_next;
  logic [PreW-1:0] r_pre, w_pre_next;
  logic [2:0]      r_bit, w_bit_next;
  logic [7:0]      r_shift, w_shift_next;
  logic            r_last, w_last_next;
  logic            r_consumed, w_consumed_next;
  logic            r_data, w_data_next;
  logic            r_clk, w_clk_next;
  logic            r_done, w_done_next;
  logic            r_busy;
  logic            r_underrun, w_underrun_next;
  logic            r_mismatch, w_mismatch_next;

  logic w_edge, w_go, w_p0, w_p1, w_fetch;

  assign w_edge  = esdi_sector & ~r_sector;
  assign w_go    = esdi_read_gate & enable;
  assign w_p0    = half_strobe & ~r_phase;
  assign w_p1    = half_strobe & r_phase;
  // Fetch window: phase-0 strobe of each byte's MSB cell.
  assign w_fetch = (r_state == StData) && w_p0 && (r_bit == 3'd0);

  assign in_tready       = w_fetch || (r_state == StDrain);
  assign esdi_read_data  = r_data;
  assign esdi_read_clock = r_clk;
  assign busy            = r_busy;
  assign sector_done     = r_done;
  assign underrun        = r_underrun;
  assign tid_mismatch    = r_mismatch;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state    <= StIdle;
      r_sector   <= 1'b0;
      r_phase    <= 1'b0;
      r_pre      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_last     <= 1'b0;
      r_consumed <= 1'b0;
      r_data     <= 1'b0;
      r_clk      <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sector   <= esdi_sector;
      r_phase    <= w_phase_next;
      r_pre      <= w_pre_next;
      r_bit      <= w_bit_next;
      r_shift    <= w_shift_next;
      r_last     <= w_last_next;
      r_consumed <= w_consumed_next;
      r_data     <= w_data_next;
      r_clk      <= w_clk_next;
      r_done     <= w_done_next;
      r_busy     <= (w_state_next != StIdle);
      r_underrun <= w_underrun_next;
      r_mismatch <= w_mismatch_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_phase_next    = r_phase;
    w_pre_next      = r_pre;
    w_bit_next      = r_bit;
    w_shift_next    = r_shift;
    w_last_next     = r_last;
    w_consumed_next = r_consumed;
    w_data_next     = r_data;
    w_clk_next      = r_clk;
    w_done_next     = 1'b0;
    w_underrun_next = r_underrun;
    w_mismatch_next = r_mismatch;
    unique case (r_state)
      StIdle: begin
        if (w_edge && enable) begin
          w_state_next    = StArmed;
          w_underrun_next = 1'b0;
          w_mismatch_next = 1'b0;
        end
      end
      StArmed: begin
        w_phase_next    = 1'b0;
        w_pre_next      = '0;
        w_bit_next      = '0;
        w_last_next     = 1'b0;
        w_consumed_next = 1'b0;
        if (!enable) begin
          w_state_next = StIdle;
        end else if (esdi_read_gate) begin
          // Gate wins over a coincident sector edge; sector_number is already the new one.
          if (!in_tvalid) begin
            w_state_next    = StMiss;
            w_underrun_next = 1'b1;
          end else if (in_tid == sector_number) begin
            w_state_next = StPreamble;
          end else begin
            w_state_next    = StMiss;
            w_mismatch_next = 1'b1;
          end
        end else if (w_edge) begin
          w_underrun_next = 1'b0;
          w_mismatch_next = 1'b0;
        end
      end
      StPreamble: begin
        if (!w_go) begin
          w_state_next = StDrain;
        end else if (w_p0) begin
          w_data_next  = 1'b0;
          w_clk_next   = 1'b0;
          w_phase_next = 1'b1;
        end else if (w_p1) begin
          w_clk_next   = 1'b1;
          w_phase_next = 1'b0;
          w_pre_next   = r_pre + PreW'(1);
          if (r_pre == PreLast) begin
            w_state_next = StSync;
            w_shift_next = SYNC_BYTE;
          end
        end
      end
      StSync: begin
        if (!w_go) begin
          w_state_next = StDrain;
        end else if (w_p0) begin
          w_data_next  = r_shift[7];
          w_shift_next = {r_shift[6:0], 1'b0};
          w_clk_next   = 1'b0;
          w_phase_next = 1'b1;
        end else if (w_p1) begin
          w_clk_next   = 1'b1;
          w_phase_next = 1'b0;
          w_bit_next   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_next = StData;
        end
      end
      StData: begin
        if (!w_go) begin
          // A tlast beat taken in this very cycle still counts as a finished frame.
          w_state_next = (r_consumed || (w_fetch && in_tvalid && in_tlast)) ? StIdle : StDrain;
        end else if (w_p0) begin
          w_clk_next   = 1'b0;
          w_phase_next = 1'b1;
          if (r_bit == 3'd0) begin
            if (in_tvalid) begin
              w_data_next     = in_tdata[7];
              w_shift_next    = {in_tdata[6:0], 1'b0};
              w_last_next     = in_tlast;
              w_consumed_next = in_tlast;
            end else begin
              w_data_next     = 1'b0;
              w_shift_next    = '0;
              w_last_next     = 1'b0;
              w_underrun_next = 1'b1;
            end
          end else begin
            w_data_next  = r_shift[7];
            w_shift_next = {r_shift[6:0], 1'b0};
          end
        end else if (w_p1) begin
          w_clk_next   = 1'b1;
          w_phase_next = 1'b0;
          w_bit_next   = r_bit + 3'd1;
          if ((r_bit == 3'd7) && r_last) begin
            w_done_next  = 1'b1;
            w_state_next = StPost;
          end
        end
      end
      StPost, StMiss: begin
        if (!w_go) begin
          w_state_next = StIdle;
        end else if (w_p0) begin
          w_data_next  = 1'b0;
          w_clk_next   = 1'b0;
          w_phase_next = 1'b1;
        end else if (w_p1) begin
          w_clk_next   = 1'b1;
          w_phase_next = 1'b0;
        end
      end
      StDrain: begin
        if (in_tvalid && in_tlast) w_state_next = StIdle;
      end
    endcase
    if (!(w_state_next inside {StPreamble, StSync, StData, StPost, StMiss})) begin
      w_data_next = 1'b0;
      w_clk_next  = 1'b0;
    end
  end

endmodule

// File: tb/tb_read_datapath.sv
// Directed bench for read_datapath: stream source queue, read-clock bit capture, immediate asserts.
module tb_read_datapath;

  logic       aclk = 1'b0;
  logic       areset, enable, esdi_sector, esdi_read_gate;
  logic [7:0] sector_number;
  logic       half_strobe = 1'b0;
  logic       in_tvalid = 1'b0, in_tlast = 1'b0;
  logic [7:0] in_tdata = 8'h00, in_tid = 8'h00;
  logic       in_tready, esdi_read_data, esdi_read_clock, busy, sector_done, underrun, tid_mismatch;

  typedef struct packed {logic [7:0] d; logic l; logic [7:0] id;} beat_t;
  beat_t q[$];
  logic  rx[$];

  int   n_checks = 0, n_err = 0;
  int   hs_count = 0, done_cnt = 0, done_at = 0;
  int   hb, db, k, rs;
  logic hs = 1'b0, prev_clk = 1'b0, src_en = 1'b1;
  logic [7:0] cnt = 8'd0;

  read_datapath #(.PREAMBLE_BITS(16), .SYNC_BYTE(8'hA1)) dut (
    .aclk(aclk), .areset(areset), .enable(enable), .sector_number(sector_number),
    .esdi_sector(esdi_sector), .half_strobe(half_strobe), .esdi_read_gate(esdi_read_gate),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata), .in_tlast(in_tlast),
    .in_tid(in_tid), .esdi_read_data(esdi_read_data), .esdi_read_clock(esdi_read_clock),
    .busy(busy), .sector_done(sector_done), .underrun(underrun), .tid_mismatch(tid_mismatch)
  );

  always #5 aclk = ~aclk;

  // Half-cell strobe every 4 clocks.
  always @(negedge aclk) begin
    cnt = cnt + 8'd1;
    half_strobe = (cnt[1:0] == 2'd0);
  end

  always @(posedge aclk) hs <= in_tvalid && in_tready;

  always @(negedge aclk) begin
    if (hs && q.size() > 0) begin
      q.delete(0);
      hs_count++;
    end
    if (src_en && q.size() > 0) begin
      in_tvalid = 1'b1; in_tdata = q[0].d; in_tlast = q[0].l; in_tid = q[0].id;
    end else begin
      in_tvalid = 1'b0; in_tdata = 8'h00; in_tlast = 1'b0; in_tid = 8'h00;
    end
  end

  always @(negedge aclk) begin
    if (esdi_read_clock && !prev_clk) rx.push_back(esdi_read_data);
    prev_clk = esdi_read_clock;
    if (sector_done) begin
      done_cnt++;
      done_at = rx.size();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic sector_pulse(input logic [7:0] sn);
    sector_number = sn;
    esdi_sector = 1'b1;
    ticks(2);
    esdi_sector = 1'b0;
    tick();
  endtask

  task automatic push(input logic [7:0] d, input logic l, input logic [7:0] id);
    q.push_back('{d: d, l: l, id: id});
  endtask

  task automatic wait_done(input int prev, input string tag);
    int n = 0;
    while (done_cnt == prev && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, 64'(done_cnt > prev), 64'd1);
  endtask

  function automatic logic [63:0] window(input int start, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) begin
      logic b;
      b = (start + i < rx.size()) ? rx[start + i] : 1'bx;
      v = {v[62:0], b};
    end
    return v;
  endfunction

  function automatic logic any_one(input int start);
    for (int i = start; i < rx.size(); i++) if (rx[i] !== 1'b0) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    areset = 1'b1; enable = 1'b1; esdi_sector = 1'b0; esdi_read_gate = 1'b0;
    sector_number = 8'd0;
    ticks(3);
    chk("reset_outputs", 64'({busy, esdi_read_data, esdi_read_clock, sector_done, underrun,
        tid_mismatch, in_tready}), 64'd0);
    areset = 1'b0;
    ticks(3);
    chk("idle_without_edge", 64'(busy), 64'd0);

    // Normal read
    push(8'h3C, 1'b0, 8'd5); push(8'h81, 1'b1, 8'd5); tick();
    sector_pulse(8'd5);
    chk("armed", 64'({busy, esdi_read_data, esdi_read_clock}), 64'b100);
    hb = hs_count; db = done_cnt; rx.delete();
    esdi_read_gate = 1'b1;
    wait_done(db, "normal_done_timeout");
    chk("normal_bits", window(0, 40), {24'h0, 16'h0, 8'hA1, 8'h3C, 8'h81});
    chk("normal_done_at_last_rise", 64'(done_at), 64'd40);
    ticks(60);
    chk("post_cells", 64'(rx.size() > 40), 64'd1);
    chk("post_zeros", 64'(any_one(40)), 64'd0);
    chk("done_one_cycle", 64'(done_cnt - db), 64'd1);
    chk("normal_beats", 64'(hs_count - hb), 64'd2);
    chk("normal_flags", 64'({underrun, tid_mismatch}), 64'd0);
    esdi_read_gate = 1'b0; ticks(2);
    chk("post_gate_drop", 64'({busy, esdi_read_data, esdi_read_clock}), 64'd0);

    // Tid mismatch, then retry on the matching sector
    push(8'h5A, 1'b0, 8'd7); push(8'hC3, 1'b1, 8'd7); tick();
    sector_pulse(8'd5);
    hb = hs_count; rx.delete();
    esdi_read_gate = 1'b1; ticks(200);
    chk("miss_flags", 64'({tid_mismatch, underrun, busy}), 64'b101);
    chk("miss_stream_pending", 64'({in_tvalid, in_tready}), 64'b10);
    chk("miss_no_beats", 64'(hs_count - hb), 64'd0);
    chk("miss_cells", 64'(rx.size() > 0), 64'd1);
    chk("miss_zeros", 64'(any_one(0)), 64'd0);
    esdi_read_gate = 1'b0; ticks(2);
    chk("miss_gate_drop", 64'({busy, tid_mismatch}), 64'b01);
    sector_pulse(8'd7);
    chk("rearm_clears_mismatch", 64'({busy, tid_mismatch}), 64'b10);
    db = done_cnt; rx.delete();
    esdi_read_gate = 1'b1;
    wait_done(db, "retry_done_timeout");
    chk("retry_bits", window(0, 40), {24'h0, 16'h0, 8'hA1, 8'h5A, 8'hC3});
    chk("retry_flags", 64'({tid_mismatch, underrun}), 64'd0);
    esdi_read_gate = 1'b0; ticks(2);

    // Underrun mid-frame, then resume
    push(8'h11, 1'b0, 8'd9); push(8'h22, 1'b0, 8'd9); push(8'h33, 1'b1, 8'd9); tick();
    sector_pulse(8'd9);
    hb = hs_count; db = done_cnt; rx.delete();
    esdi_read_gate = 1'b1;
    k = 0;
    while (hs_count - hb < 2 && k < 2000) begin tick(); k++; end
    chk("ur_two_beats", 64'(hs_count - hb), 64'd2);
    src_en = 1'b0;
    k = 0;
    while (!underrun && k < 500) begin tick(); k++; end
    chk("ur_flag", 64'(underrun), 64'd1);
    src_en = 1'b1;
    wait_done(db, "ur_done_timeout");
    chk("ur_bits", window(0, 56), {8'h0, 16'h0, 8'hA1, 8'h11, 8'h22, 8'h00, 8'h33});
    chk("ur_beats", 64'(hs_count - hb), 64'd3);
    chk("ur_sticky", 64'({underrun, tid_mismatch}), 64'b10);
    esdi_read_gate = 1'b0; ticks(2);

    // Gate abort after 4 data bits, remainder drained
    push(8'hF0, 1'b0, 8'd2); push(8'h0F, 1'b0, 8'd2);
    push(8'hAA, 1'b0, 8'd2); push(8'h55, 1'b1, 8'd2); tick();
    sector_pulse(8'd2);
    hb = hs_count; rx.delete();
    esdi_read_gate = 1'b1;
    k = 0;
    while (rx.size() < 28 && k < 2000) begin tick(); k++; end
    chk("abort_reach", 64'(rx.size()), 64'd28);
    chk("abort_first_nibble", window(24, 4), 64'hF);
    esdi_read_gate = 1'b0; tick();
    chk("abort_outputs_zero", 64'({busy, esdi_read_data, esdi_read_clock}), 64'b100);
    k = 0;
    while (busy && k < 100) begin tick(); k++; end
    chk("abort_drained_beats", 64'(hs_count - hb), 64'd4);
    chk("abort_idle", 64'({busy, in_tready}), 64'd0);
    chk("abort_no_more_bits", 64'(rx.size()), 64'd28);
    chk("abort_queue_empty", 64'(q.size()), 64'd0);

    // Asynchronous reset during SYNC
    push(8'h77, 1'b1, 8'd4); tick();
    sector_pulse(8'd4);
    rx.delete();
    esdi_read_gate = 1'b1;
    k = 0;
    while (rx.size() < 19 && k < 2000) begin tick(); k++; end
    rs = rx.size();
    #2 areset = 1'b1;
    #1;
    chk("areset_outputs", 64'({busy, esdi_read_data, esdi_read_clock, sector_done, underrun,
        tid_mismatch, in_tready}), 64'd0);
    q.delete();
    tick();
    areset = 1'b0;
    ticks(30);
    chk("after_reset_waits", 64'(busy), 64'd0);
    chk("after_reset_no_cells", 64'(rx.size()), 64'(rs));
    push(8'h77, 1'b1, 8'd4); tick();
    hb = hs_count; db = done_cnt; rx.delete();
    sector_pulse(8'd4);
    wait_done(db, "recover_done_timeout");
    chk("recover_bits", window(0, 32), {32'h0, 16'h0, 8'hA1, 8'h77});
    chk("recover_beats", 64'(hs_count - hb), 64'd1);
    esdi_read_gate = 1'b0; ticks(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
